ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_filter.sv | 59 +++++
 rtl/ps2_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encodings,
// default parameter values and the odd-parity helper.
package ps2_pkg;

    localparam int DEFAULT_FIFO_DEPTH     = 8;
    localparam int DEFAULT_FILTER_LEN     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 5000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // True when the eight data bits plus the parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings the raw PS/2 lines into the clk domain, debounces the PS/2 clock
// and produces a single-cycle pulse on each accepted falling edge.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall_edge
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic          clk_filt;
    logic [CW-1:0] stable_cnt;

    // Two-flop synchronisers; idle-high lines reset to 1 so no false edge appears
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clock;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Accept a new clock level only after FILTER_LEN identical differing samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_filt   <= 1'b1;
            stable_cnt <= '0;
            fall_edge  <= 1'b0;
        end else begin
            fall_edge <= 1'b0;
            if (clk_sync == clk_filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt   <= clk_sync;
                stable_cnt <= '0;
                fall_edge  <= ~clk_sync;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: frame decoder FSM with parity/stop/timeout checks
// feeding a first-word-fall-through scan-code FIFO.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clock,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic                          scan_ready,
    output logic [7:0]                    scan_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    logic            data_sync;
    logic            fall_edge;

    ps2_state_t      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_ok;
    logic [TW-1:0]   timeout_cnt;
    logic            push_req;
    logic [7:0]      push_byte;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            fifo_full;
    logic            do_pop;
    logic            do_push;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .data_sync (data_sync),
        .fall_edge (fall_edge)
    );

    // Frame decoder: one state step per filtered falling edge, plus idle timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            parity_ok   <= 1'b0;
            timeout_cnt <= '0;
            push_req    <= 1'b0;
            push_byte   <= 8'h00;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            push_req   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_edge) begin
                timeout_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!data_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {data_sync, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state   <= ST_PARITY;
                            bit_cnt <= 3'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        parity_ok <= odd_parity_ok(shift_reg, data_sync);
                        state     <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!data_sync) begin
                            frame_err <= 1'b1;
                        end else if (!parity_ok) begin
                            parity_err <= 1'b1;
                        end else begin
                            push_req  <= 1'b1;
                            push_byte <= shift_reg;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state       <= ST_IDLE;
                    bit_cnt     <= 3'd0;
                    timeout_cnt <= '0;
                    frame_err   <= 1'b1;
                end else begin
                    timeout_cnt <= timeout_cnt + TW'(1);
                end
            end else begin
                timeout_cnt <= '0;
            end
        end
    end

    assign fifo_full = (fifo_count == CNTW'(FIFO_DEPTH));
    assign do_pop    = rd_en && (fifo_count != '0);
    assign do_push   = push_req && (!fifo_full || do_pop);

    // Storage array; a push while full is only allowed alongside a pop, which frees the head slot
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                fifo_count <= fifo_count + CNTW'(1);
            end else if (do_pop && !do_push) begin
                fifo_count <= fifo_count - CNTW'(1);
            end
            if (push_req && fifo_full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign scan_ready = (fifo_count != '0);
    assign scan_code  = scan_ready ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: good frames, parity/stop errors, glitch
// rejection, timeout, overflow, full push+pop and reset mid-frame.
module tb_ps2_rx_fifo;

    localparam int FIFO_DEPTH     = 4;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;
    int perr_pulses = 0;
    int ferr_pulses = 0;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Count every cycle an error output is high so stretched pulses are visible
    always @(negedge clk) begin
        if (parity_err === 1'b1) perr_pulses++;
        if (frame_err === 1'b1) ferr_pulses++;
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clock = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clock = 1'b1;
    endtask

    // Full 11-bit frame; optionally pulses rd_en in the exact cycle the byte is pushed
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit pop_at_push);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        ps2_data = stp;
        repeat (HALF) @(negedge clk);
        ps2_clock = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            rd_en = (pop_at_push && i == FILTER_LEN + 3) ? 1'b1 : 1'b0;
        end
        ps2_clock = 1'b1;
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        vectors += 6;
        if (scan_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", scan_ready); end
        if (scan_code !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_code: got %h want 00", scan_code); end
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", fifo_count); end
        if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_perr: got %b want 0", parity_err); end
        if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ferr: got %b want 0", frame_err); end
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame();
        perr_pulses = 0; ferr_pulses = 0;
        send_frame(8'h1E, 1'b1, 1'b1, 1'b0);
        vectors += 5;
        if (scan_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL good_ready: got %b want 1", scan_ready); end
        if (scan_code !== 8'h1E) begin miscompares++; $display("[TB] FAIL good_code: got %h want 1e", scan_code); end
        if (fifo_count !== 3'd1) begin miscompares++; $display("[TB] FAIL good_count: got %0d want 1", fifo_count); end
        if (perr_pulses != 0) begin miscompares++; $display("[TB] FAIL good_perr: got %0d want 0", perr_pulses); end
        if (ferr_pulses != 0) begin miscompares++; $display("[TB] FAIL good_ferr: got %0d want 0", ferr_pulses); end
        do_pop();
        vectors += 2;
        if (scan_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL good_pop_ready: got %b want 0", scan_ready); end
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL good_pop_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_parity_error();
        perr_pulses = 0; ferr_pulses = 0;
        send_frame(8'h1E, 1'b0, 1'b1, 1'b0);
        vectors += 3;
        if (perr_pulses != 1) begin miscompares++; $display("[TB] FAIL par_perr: got %0d want 1", perr_pulses); end
        if (ferr_pulses != 0) begin miscompares++; $display("[TB] FAIL par_ferr: got %0d want 0", ferr_pulses); end
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL par_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_stop_error();
        perr_pulses = 0; ferr_pulses = 0;
        send_frame(8'h1E, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1E, 1'b0, 1'b0, 1'b0);
        vectors += 3;
        if (ferr_pulses != 2) begin miscompares++; $display("[TB] FAIL stop_ferr: got %0d want 2", ferr_pulses); end
        if (perr_pulses != 0) begin miscompares++; $display("[TB] FAIL stop_perr: got %0d want 0", perr_pulses); end
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL stop_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_glitch();
        perr_pulses = 0; ferr_pulses = 0;
        ps2_data = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clock = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clock = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        vectors += 4;
        if (scan_code !== 8'h1C) begin miscompares++; $display("[TB] FAIL glitch_code: got %h want 1c", scan_code); end
        if (fifo_count !== 3'd1) begin miscompares++; $display("[TB] FAIL glitch_count: got %0d want 1", fifo_count); end
        if (ferr_pulses != 0) begin miscompares++; $display("[TB] FAIL glitch_ferr: got %0d want 0", ferr_pulses); end
        if (perr_pulses != 0) begin miscompares++; $display("[TB] FAIL glitch_perr: got %0d want 0", perr_pulses); end
        do_pop();
    endtask

    // Edge seen FILTER_LEN+3 cycles after the line drop; timeout fires TIMEOUT_CYCLES later
    task automatic test_timeout();
        int first_hit;
        perr_pulses = 0; ferr_pulses = 0;
        first_hit = -1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clock = 1'b0;
        for (int i = 1; i <= FILTER_LEN + TIMEOUT_CYCLES + 12; i++) begin
            @(negedge clk);
            if (i == HALF) ps2_clock = 1'b1;
            if (frame_err === 1'b1 && first_hit < 0) first_hit = i;
        end
        vectors += 3;
        if (first_hit != FILTER_LEN + TIMEOUT_CYCLES + 3) begin
            miscompares++; $display("[TB] FAIL timeout_cycle: got %0d want %0d", first_hit, FILTER_LEN + TIMEOUT_CYCLES + 3);
        end
        if (ferr_pulses != 1) begin miscompares++; $display("[TB] FAIL timeout_pulses: got %0d want 1", ferr_pulses); end
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL timeout_count: got %0d want 0", fifo_count); end
        send_frame(8'h45, 1'b0, 1'b1, 1'b0);
        vectors += 2;
        if (scan_code !== 8'h45) begin miscompares++; $display("[TB] FAIL timeout_next_code: got %h want 45", scan_code); end
        if (fifo_count !== 3'd1) begin miscompares++; $display("[TB] FAIL timeout_next_count: got %0d want 1", fifo_count); end
        do_pop();
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic [7:0] exp_code;
        for (int v = 1; v <= 5; v++) begin
            b = 8'(v);
            send_frame(b, ~^b, 1'b1, 1'b0);
        end
        vectors += 2;
        if (fifo_count !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_count: got %0d want 4", fifo_count); end
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
        for (int k = 0; k < 4; k++) begin
            exp_code = 8'(k + 1);
            vectors++;
            if (scan_code !== exp_code) begin miscompares++; $display("[TB] FAIL ovf_pop%0d: got %h want %h", k, scan_code, exp_code); end
            do_pop();
        end
        vectors += 2;
        if (scan_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_empty_ready: got %b want 0", scan_ready); end
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL ovf_empty_count: got %0d want 0", fifo_count); end
        do_pop();
        vectors += 2;
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL empty_pop_count: got %0d want 0", fifo_count); end
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] fill [5];
        logic [7:0] b;
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h55;
        for (int k = 0; k < 4; k++) begin
            b = fill[k];
            send_frame(b, ~^b, 1'b1, 1'b0);
        end
        b = fill[4];
        send_frame(b, ~^b, 1'b1, 1'b1);
        vectors++;
        if (fifo_count !== 3'd4) begin miscompares++; $display("[TB] FAIL pushpop_count: got %0d want 4", fifo_count); end
        for (int k = 1; k < 5; k++) begin
            vectors++;
            if (scan_code !== fill[k]) begin miscompares++; $display("[TB] FAIL pushpop_pop%0d: got %h want %h", k, scan_code, fill[k]); end
            do_pop();
        end
        vectors++;
        if (scan_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL pushpop_empty: got %b want 0", scan_ready); end
    endtask

    task automatic test_reset_mid_frame();
        perr_pulses = 0; ferr_pulses = 0;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 6;
        if (scan_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ready: got %b want 0", scan_ready); end
        if (scan_code !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_code: got %h want 00", scan_code); end
        if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_count: got %0d want 0", fifo_count); end
        if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_perr: got %b want 0", parity_err); end
        if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ferr: got %b want 0", frame_err); end
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ovf: got %b want 0", overflow); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        ferr_pulses = 0; perr_pulses = 0;
        send_frame(8'h1E, 1'b1, 1'b1, 1'b0);
        vectors += 4;
        if (scan_code !== 8'h1E) begin miscompares++; $display("[TB] FAIL mid_next_code: got %h want 1e", scan_code); end
        if (fifo_count !== 3'd1) begin miscompares++; $display("[TB] FAIL mid_next_count: got %0d want 1", fifo_count); end
        if (ferr_pulses != 0) begin miscompares++; $display("[TB] FAIL mid_next_ferr: got %0d want 0", ferr_pulses); end
        if (perr_pulses != 0) begin miscompares++; $display("[TB] FAIL mid_next_perr: got %0d want 0", perr_pulses); end
    endtask

    // Scenario sequence
    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_timeout();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
